// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default widths, butterfly mode encoding
// and a width-generic saturating clamp.
package fft_pkg;

    localparam int FFT_DATA_W  = 12;
    localparam int FFT_TW_W    = 12;
    localparam int FFT_TW_FRAC = 10;
    localparam int FFT_CNT_W   = 16;

    typedef enum logic {
        MODE_DIF = 1'b0,
        MODE_DIT = 1'b1
    } mode_e;

    // Wide carrier for the clamp; callers sign-extend into it and slice back out.
    localparam int SAT_W = 64;

    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] v,
        input int                      out_w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/butterfly_pipe_if.sv
// Streaming port bundle of the pipelined butterfly: input pair, twiddle,
// valid/ready handshakes on both sides and overflow reporting.
interface butterfly_pipe_if
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int TW_W   = FFT_TW_W,
    parameter int CNT_W  = FFT_CNT_W
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic                     mode;
    logic                     scale;
    logic signed [DATA_W-1:0] x1_r;
    logic signed [DATA_W-1:0] x1_i;
    logic signed [DATA_W-1:0] x2_r;
    logic signed [DATA_W-1:0] x2_i;
    logic signed [TW_W-1:0]   w_r;
    logic signed [TW_W-1:0]   w_i;

    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] X1_r;
    logic signed [DATA_W-1:0] X1_i;
    logic signed [DATA_W-1:0] X2_r;
    logic signed [DATA_W-1:0] X2_i;
    logic                     ovf;
    logic [CNT_W-1:0]         ovf_cnt;
    logic                     clr_ovf;

    modport master (
        output in_valid, mode, scale, x1_r, x1_i, x2_r, x2_i, w_r, w_i,
        output out_ready, clr_ovf,
        input  in_ready, out_valid, X1_r, X1_i, X2_r, X2_i, ovf, ovf_cnt
    );

    modport slave (
        input  in_valid, mode, scale, x1_r, x1_i, x2_r, x2_i, w_r, w_i,
        input  out_ready, clr_ovf,
        output in_ready, out_valid, X1_r, X1_i, X2_r, X2_i, ovf, ovf_cnt
    );

endinterface

// File: rtl/cmplx_mult_pipe.sv
// One-stage registered full-precision complex multiplier with clock enable;
// shared between the butterfly and the twiddle-ROM datapath.
module cmplx_mult_pipe #(
    parameter int A_W = 13,
    parameter int B_W = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic signed [A_W-1:0]  a_r_i,
    input  logic signed [A_W-1:0]  a_i_i,
    input  logic signed [B_W-1:0]  b_r_i,
    input  logic signed [B_W-1:0]  b_i_i,
    output logic signed [A_W+B_W:0] p_r_o,
    output logic signed [A_W+B_W:0] p_i_o
);

    localparam int M_W = A_W + B_W;
    localparam int P_W = M_W + 1;

    logic signed [M_W-1:0] rr, ii, ri, ir;
    logic signed [P_W-1:0] p_r_d, p_i_d;
    logic signed [P_W-1:0] p_r_q, p_i_q;

    assign rr = M_W'(a_r_i) * M_W'(b_r_i);
    assign ii = M_W'(a_i_i) * M_W'(b_i_i);
    assign ri = M_W'(a_r_i) * M_W'(b_i_i);
    assign ir = M_W'(a_i_i) * M_W'(b_r_i);

    // The extra bit keeps (-2^(A_W-1))*(-2^(B_W-1)) sums from wrapping.
    assign p_r_d = P_W'(rr) - P_W'(ii);
    assign p_i_d = P_W'(ri) + P_W'(ir);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_r_q <= '0;
            p_i_q <= '0;
        end else if (en_i) begin
            p_r_q <= p_r_d;
            p_i_q <= p_i_d;
        end
    end

    assign p_r_o = p_r_q;
    assign p_i_o = p_i_q;

endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage radix-2 complex butterfly (DIF or DIT per sample) with optional
// divide-by-2, output saturation and a sticky overflow event counter.
module butterfly_pipe
    import fft_pkg::*;
#(
    parameter int DATA_W  = FFT_DATA_W,
    parameter int TW_W    = FFT_TW_W,
    parameter int TW_FRAC = FFT_TW_FRAC,
    parameter int CNT_W   = FFT_CNT_W
) (
    input logic             clk,
    input logic             rst,
    butterfly_pipe_if.slave bus
);

    localparam int S1_W  = DATA_W + 1;
    localparam int P_W   = S1_W + TW_W + 1;
    localparam int SUM_W = P_W + 1;

    // One enable for the whole pipe: it moves only when the output slot frees up.
    logic adv;
    logic out_valid_q;

    assign adv         = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = adv;

    // Stage 1: DIF pre-add/subtract or DIT pass-through, twiddle capture.
    logic signed [S1_W-1:0] s1_a_r_d, s1_a_i_d, s1_b_r_d, s1_b_i_d;
    logic signed [S1_W-1:0] s1_a_r_q, s1_a_i_q, s1_b_r_q, s1_b_i_q;
    logic signed [TW_W-1:0] s1_w_r_q, s1_w_i_q;
    logic                   s1_valid_q;
    mode_e                  s1_mode_q;
    logic                   s1_scale_q;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        s1_a_r_d = S1_W'(bus.x1_r);
        s1_a_i_d = S1_W'(bus.x1_i);
        s1_b_r_d = S1_W'(bus.x2_r);
        s1_b_i_d = S1_W'(bus.x2_i);
        if (mode_e'(bus.mode) == MODE_DIF) begin
            s1_a_r_d = S1_W'(bus.x1_r) + S1_W'(bus.x2_r);
            s1_a_i_d = S1_W'(bus.x1_i) + S1_W'(bus.x2_i);
            s1_b_r_d = S1_W'(bus.x1_r) - S1_W'(bus.x2_r);
            s1_b_i_d = S1_W'(bus.x1_i) - S1_W'(bus.x2_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: data registers are reset as well as valids, so the outputs
            // read a deterministic zero straight after reset.
            s1_valid_q <= 1'b0;
            s1_mode_q  <= MODE_DIF;
            s1_scale_q <= 1'b0;
            s1_a_r_q   <= '0;
            s1_a_i_q   <= '0;
            s1_b_r_q   <= '0;
            s1_b_i_q   <= '0;
            s1_w_r_q   <= '0;
            s1_w_i_q   <= '0;
        end else if (adv) begin
            // NOTE: non-blocking assignments let each stage capture the value the
            // previous stage held before this edge.
            s1_valid_q <= bus.in_valid;
            s1_mode_q  <= mode_e'(bus.mode);
            s1_scale_q <= bus.scale;
            s1_a_r_q   <= s1_a_r_d;
            s1_a_i_q   <= s1_a_i_d;
            s1_b_r_q   <= s1_b_r_d;
            s1_b_i_q   <= s1_b_i_d;
            s1_w_r_q   <= bus.w_r;
            s1_w_i_q   <= bus.w_i;
        end
    end

    // Stage 2: complex product of the second operand and the twiddle.
    logic signed [P_W-1:0]  s2_p_r, s2_p_i;
    logic signed [S1_W-1:0] s2_a_r_q, s2_a_i_q;
    logic                   s2_valid_q;
    mode_e                  s2_mode_q;
    logic                   s2_scale_q;

    cmplx_mult_pipe #(
        .A_W(S1_W),
        .B_W(TW_W)
    ) u_mult (
        .clk  (clk),
        .rst  (rst),
        .en_i (adv),
        .a_r_i(s1_b_r_q),
        .a_i_i(s1_b_i_q),
        .b_r_i(s1_w_r_q),
        .b_i_i(s1_w_i_q),
        .p_r_o(s2_p_r),
        .p_i_o(s2_p_i)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_mode_q  <= MODE_DIF;
            s2_scale_q <= 1'b0;
            s2_a_r_q   <= '0;
            s2_a_i_q   <= '0;
        end else if (adv) begin
            s2_valid_q <= s1_valid_q;
            s2_mode_q  <= s1_mode_q;
            s2_scale_q <= s1_scale_q;
            s2_a_r_q   <= s1_a_r_q;
            s2_a_i_q   <= s1_a_i_q;
        end
    end

    // Stage 3: final add/subtract, scaling shifts and saturation.
    // Component order in the arrays: X1_r, X1_i, X2_r, X2_i.
    logic signed [SUM_W-1:0]  t_r, t_i;
    logic signed [SUM_W-1:0]  y     [4];
    logic signed [SAT_W-1:0]  sat_v [4];
    logic signed [DATA_W-1:0] res_d [4];
    logic signed [DATA_W-1:0] res_q [4];
    logic                     ovf_d;
    logic                     ovf_q;

    always_comb begin
        t_r  = SUM_W'(s2_p_r >>> TW_FRAC);
        t_i  = SUM_W'(s2_p_i >>> TW_FRAC);
        y[0] = SUM_W'(s2_a_r_q) >>> s2_scale_q;
        y[1] = SUM_W'(s2_a_i_q) >>> s2_scale_q;
        y[2] = SUM_W'(s2_p_r) >>> (TW_FRAC + int'(s2_scale_q));
        y[3] = SUM_W'(s2_p_i) >>> (TW_FRAC + int'(s2_scale_q));
        if (s2_mode_q == MODE_DIT) begin
            y[0] = (SUM_W'(s2_a_r_q) + t_r) >>> s2_scale_q;
            y[1] = (SUM_W'(s2_a_i_q) + t_i) >>> s2_scale_q;
            y[2] = (SUM_W'(s2_a_r_q) - t_r) >>> s2_scale_q;
            y[3] = (SUM_W'(s2_a_i_q) - t_i) >>> s2_scale_q;
        end
        ovf_d = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sat_v[k] = saturate(SAT_W'(y[k]), DATA_W);
            res_d[k] = sat_v[k][DATA_W-1:0];
            ovf_d    = ovf_d | (sat_v[k] != SAT_W'(y[k]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            for (int k = 0; k < 4; k++) res_q[k] <= '0;
        end else if (adv) begin
            out_valid_q <= s2_valid_q;
            ovf_q       <= ovf_d;
            for (int k = 0; k < 4; k++) res_q[k] <= res_d[k];
        end
    end

    // Overflow events are counted on transfer, so a stalled result counts once.
    logic [CNT_W-1:0] ovf_cnt_d, ovf_cnt_q;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (bus.clr_ovf) begin
            ovf_cnt_d = '0;
        end else if (out_valid_q && bus.out_ready && ovf_q && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_cnt_q <= '0;
        else     ovf_cnt_q <= ovf_cnt_d;
    end

    assign bus.out_valid = out_valid_q;
    assign bus.X1_r      = res_q[0];
    assign bus.X1_i      = res_q[1];
    assign bus.X2_r      = res_q[2];
    assign bus.X2_i      = res_q[3];
    assign bus.ovf       = ovf_q;
    assign bus.ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Scoreboard bench for butterfly_pipe: directed cases, backpressure, random
// traffic and mid-stream reset against an arithmetic reference model.
module tb_butterfly_pipe;

    localparam int DATA_W  = 12;
    localparam int TW_W    = 12;
    localparam int TW_FRAC = 10;
    localparam int CNT_W   = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    butterfly_pipe_if #(.DATA_W(DATA_W), .TW_W(TW_W), .CNT_W(CNT_W)) bus ();

    butterfly_pipe #(
        .DATA_W (DATA_W),
        .TW_W   (TW_W),
        .TW_FRAC(TW_FRAC),
        .CNT_W  (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int x1r, x1i, x2r, x2i, wr, wi;
        bit dit, scale;
    } stim_t;

    typedef struct {
        longint y1r, y1i, y2r, y2i;
        bit     ovf;
        int     cyc;
        bit     chk_lat;
    } exp_t;

    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc      = 0;
    exp_t   sb[$];
    longint exp_cnt  = 0;
    bit     lat_mode = 1'b0;
    int     rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic longint clamp(input longint v, output bit hit);
        longint lim;
        lim = longint'(1) <<< (DATA_W - 1);
        hit = (v > lim - 1) || (v < -lim);
        if (v > lim - 1) return lim - 1;
        if (v < -lim) return -lim;
        return v;
    endfunction

    // Butterfly equations evaluated with plain 64-bit integer arithmetic.
    function automatic exp_t model(input stim_t s);
        exp_t   e;
        longint ar, ai, br, bi, pr, pi, tr, ti;
        longint r0, r1, r2, r3;
        bit     h0, h1, h2, h3;
        if (!s.dit) begin
            ar = longint'(s.x1r) + s.x2r;
            ai = longint'(s.x1i) + s.x2i;
            br = longint'(s.x1r) - s.x2r;
            bi = longint'(s.x1i) - s.x2i;
            pr = br * s.wr - bi * s.wi;
            pi = br * s.wi + bi * s.wr;
            r0 = ar >>> s.scale;
            r1 = ai >>> s.scale;
            r2 = pr >>> (TW_FRAC + int'(s.scale));
            r3 = pi >>> (TW_FRAC + int'(s.scale));
        end else begin
            pr = longint'(s.x2r) * s.wr - longint'(s.x2i) * s.wi;
            pi = longint'(s.x2r) * s.wi + longint'(s.x2i) * s.wr;
            tr = pr >>> TW_FRAC;
            ti = pi >>> TW_FRAC;
            r0 = (s.x1r + tr) >>> s.scale;
            r1 = (s.x1i + ti) >>> s.scale;
            r2 = (s.x1r - tr) >>> s.scale;
            r3 = (s.x1i - ti) >>> s.scale;
        end
        e.y1r = clamp(r0, h0);
        e.y1i = clamp(r1, h1);
        e.y2r = clamp(r2, h2);
        e.y2i = clamp(r3, h3);
        e.ovf = h0 | h1 | h2 | h3;
        e.cyc = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    // Monitor: everything sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin : monitor
        exp_t  e;
        stim_t s;
        bit    xfer_ovf;
        if (!rst) begin
            xfer_ovf = 1'b0;
            check("in_ready", longint'(bus.in_ready), longint'(!bus.out_valid || bus.out_ready));
            check("ovf_cnt", longint'(bus.ovf_cnt), exp_cnt);
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious out_valid", longint'(bus.out_valid), 0);
                end else begin
                    e = sb[0];
                    check("X1_r", longint'(bus.X1_r), e.y1r);
                    check("X1_i", longint'(bus.X1_i), e.y1i);
                    check("X2_r", longint'(bus.X2_r), e.y2r);
                    check("X2_i", longint'(bus.X2_i), e.y2i);
                    check("ovf", longint'(bus.ovf), longint'(e.ovf));
                    if (bus.out_ready) begin
                        if (e.chk_lat) check("latency", longint'(cyc - e.cyc), 3);
                        xfer_ovf = e.ovf;
                        void'(sb.pop_front());
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                s.x1r = int'(bus.x1_r);  s.x1i = int'(bus.x1_i);
                s.x2r = int'(bus.x2_r);  s.x2i = int'(bus.x2_i);
                s.wr  = int'(bus.w_r);   s.wi  = int'(bus.w_i);
                s.dit = bus.mode;        s.scale = bus.scale;
                e = model(s);
                e.cyc = cyc;
                e.chk_lat = lat_mode;
                sb.push_back(e);
            end
            if (bus.clr_ovf) exp_cnt = 0;
            else if (xfer_ovf && exp_cnt != (longint'(1) <<< CNT_W) - 1) exp_cnt++;
        end
    end

    // Downstream ready: constant, fixed 1,0,0,1 pattern, or random.
    initial begin : ready_gen
        int idx = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    bus.out_ready = (idx % 4 == 0) || (idx % 4 == 3);
                    idx++;
                end
                2:       bus.out_ready = 1'($urandom_range(1));
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int x1r, input int x1i, input int x2r, input int x2i,
                         input int wr, input int wi, input bit dit, input bit sc);
        int n = 0;
        bus.x1_r = DATA_W'(x1r);  bus.x1_i = DATA_W'(x1i);
        bus.x2_r = DATA_W'(x2r);  bus.x2_i = DATA_W'(x2i);
        bus.w_r  = TW_W'(wr);     bus.w_i  = TW_W'(wi);
        bus.mode = dit;           bus.scale = sc;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 100);
        if (!bus.in_ready) check("in_ready timeout", longint'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    function automatic int rnd_data();
        return int'($urandom_range(4095)) - 2048;
    endfunction

    initial begin : driver
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.clr_ovf  = 1'b0;
        bus.mode = 1'b0;  bus.scale = 1'b0;
        bus.x1_r = '0;  bus.x1_i = '0;  bus.x2_r = '0;  bus.x2_i = '0;
        bus.w_r  = '0;  bus.w_i  = '0;
        cycles(3);
        check("reset out_valid", longint'(bus.out_valid), 0);
        check("reset ovf", longint'(bus.ovf), 0);
        check("reset ovf_cnt", longint'(bus.ovf_cnt), 0);
        check("reset X1_r", longint'(bus.X1_r), 0);
        check("reset X2_i", longint'(bus.X2_i), 0);
        rst = 1'b0;
        cycles(2);

        // Directed cases with an idle pipe and ready held high.
        lat_mode = 1'b1;
        drive(100, 50, 20, 10, 1024, 0, 1'b0, 1'b0);
        cycles(5);
        drive(2000, -2048, 2000, -2048, 1024, 0, 1'b0, 1'b0);
        cycles(5);
        check("ovf_cnt after saturation", longint'(bus.ovf_cnt), 1);
        bus.clr_ovf = 1'b1;
        cycles(1);
        bus.clr_ovf = 1'b0;
        check("ovf_cnt after clear", longint'(bus.ovf_cnt), 0);
        drive(100, 0, 0, 50, 0, -1024, 1'b1, 1'b0);
        cycles(5);
        drive(100, 50, 20, 10, 1024, 0, 1'b0, 1'b1);
        cycles(5);
        drive(-2, 0, -1, 0, 1024, 0, 1'b0, 1'b1);
        cycles(5);
        drive(2047, 2047, -2048, -2048, -1024, -1024, 1'b1, 1'b0);
        cycles(5);

        // Backpressure: 8 back-to-back pairs, mode/scale varying per sample.
        lat_mode = 1'b0;
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) begin
            drive(100 * i - 300, 37 * i, 11 - 5 * i, 90 - 13 * i,
                  1024 - 100 * i, 60 * i - 200, 1'(i % 2), 1'((i / 2) % 2));
        end
        rdy_mode = 0;
        cycles(10);

        // Random traffic with random ready, gaps and occasional clears.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            bus.clr_ovf = ($urandom_range(15) == 0);
            drive(rnd_data(), rnd_data(), rnd_data(), rnd_data(),
                  int'($urandom_range(2048)) - 1024, int'($urandom_range(2048)) - 1024,
                  1'($urandom_range(1)), 1'($urandom_range(1)));
            if ($urandom_range(3) == 0) cycles(1);
        end
        bus.clr_ovf = 1'b0;
        rdy_mode = 0;
        cycles(10);

        // Mid-stream reset with samples in flight and a non-zero counter.
        drive(2000, 2000, 2000, 2000, 1024, 0, 1'b0, 1'b0);
        cycles(5);
        drive(1, 2, 3, 4, 1024, 0, 1'b0, 1'b0);
        drive(5, 6, 7, 8, 1024, 0, 1'b1, 1'b0);
        drive(9, 10, 11, 12, 1024, 0, 1'b0, 1'b1);
        #1;
        rst = 1'b1;
        sb.delete();
        exp_cnt = 0;
        #1;
        check("async reset out_valid", longint'(bus.out_valid), 0);
        check("async reset ovf_cnt", longint'(bus.ovf_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycles(2);
        lat_mode = 1'b1;
        drive(-500, 300, 200, -100, 724, -724, 1'b1, 1'b1);
        cycles(6);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        check("scoreboard drained", longint'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
- Pipelined, parametrised radix-2 complex butterfly for the FFT datapath; next generation of the combinational 12-bit DIF butterfly.
- Adds a 3-stage register pipeline with valid/ready flow control.
- Adds per-sample DIF/DIT mode select and optional divide-by-2 stage scaling.
- Adds a saturation flag aligned with each output, plus a sticky saturating overflow counter for block-floating-point control.

Parameters:
DATA_W, 12, width of signed complex data components
TW_W, 12, width of signed twiddle components
TW_FRAC, 10, twiddle fractional bits (1.0 = 2^TW_FRAC)
CNT_W, 16, width of overflow event counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  input sample pair valid
in_ready  out  1  block can accept input this cycle
mode  in  1  0 = DIF, 1 = DIT; sampled with input
scale  in  1  1 = outputs arithmetically shifted right by 1; sampled with input
x1_r, x1_i, x2_r, x2_i  in  DATA_W each  signed input pair
w_r, w_i  in  TW_W each  signed twiddle
out_valid  out  1  output valid
out_ready  in  1  downstream accepts output
X1_r, X1_i, X2_r, X2_i  out  DATA_W each  signed saturated results
ovf  out  1  any of the four outputs of the current result saturated
ovf_cnt  out  CNT_W  count of transferred results with ovf=1; saturates at all-ones
clr_ovf  in  1  synchronous clear of ovf_cnt

Behaviour:
- Reset: asynchronous, active-high. All pipeline valids, out_valid, ovf, ovf_cnt, X*, and all data registers go to 0. Reset mid-operation discards in-flight samples; first output after release comes 3 accepted-and-advanced cycles after the first accepted input.
- Flow control: global advance enable adv = ~out_valid | out_ready.
  - in_ready = adv.
  - Input is accepted when in_valid & in_ready.
  - When adv=0, all stages hold; outputs stay stable while out_valid=1 and out_ready=0.
  - Bubbles propagate as valid=0 entries.
- Latency: exactly 3 clk from acceptance to out_valid when out_ready is held high. Throughput: 1 pair per cycle.
- mode and scale are carried down the pipeline with their sample; consecutive samples may differ.
- Stage 1:
  - DIF: a = x1+x2 and d = x1-x2, each at DATA_W+1 bits.
  - DIT: register x1 and x2 unchanged.
  - Twiddle registered in both modes.
- Stage 2: complex multiply, full precision (DATA_W+1+TW_W bits per product, +1 bit for the sum/difference).
  - DIF: p = d*w.
  - DIT: p = x2*w.
  - p_r = pr_r*w_r - pr_i*w_i; p_i = pr_r*w_i + pr_i*w_r.
- Stage 3: output computation.
  - DIF: X1 = a >>> scale; X2 = p >>> (TW_FRAC+scale).
  - DIT: t = p >>> TW_FRAC; X1 = (x1+t) >>> scale; X2 = (x1-t) >>> scale.
  - All shifts are arithmetic (truncate toward -inf); no rounding.
  - Intermediate widths are wide enough that no wrap occurs before saturation.
- Saturation: after all shifts, clamp each component to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. ovf = OR of the four clamp events, registered with the outputs.
- ovf_cnt:
  - Increments by 1 on each transfer (out_valid & out_ready) with ovf=1.
  - Holds at 2^CNT_W-1.
  - clr_ovf forces 0 next cycle and wins over a simultaneous increment.
- Twiddle -1.0 (-2^TW_FRAC) is legal; +1.0 must fit within TW_W (guaranteed by the default parameters).

Decomposition:
- Shared package fft_pkg:
  - DATA_W, TW_W and TW_FRAC defaults.
  - MODE_DIF = 0, MODE_DIT = 1.
  - A saturate function (width-generic clamp helper).
- One sub-module, cmplx_mult_pipe: one-stage registered complex multiplier with enable. Reused by the twiddle-ROM datapath.

Test Plan:
- DIF, scale=0, x1=(100,50), x2=(20,10), w=(1024,0), out_ready=1 -> after 3 cycles X1=(120,60), X2=(80,40), ovf=0.
- DIF saturation: x1=(2000,-2048), x2=(2000,-2048), w=(1024,0) -> X1=(2047,-2048), X2=(0,0), ovf=1, ovf_cnt=1; then clr_ovf=1 -> ovf_cnt=0.
- DIT, w=(0,-1024) (-j), x1=(100,0), x2=(0,50) -> t=(50,0), X1=(150,0), X2=(50,0).
- Scaling:
  - DIF, scale=1, x1=(100,50), x2=(20,10), w=(1024,0) -> X1=(60,30), X2=(40,20).
  - x1=(-2,0), x2=(-1,0) -> X1_r=-2 (truncation toward -inf).
- Backpressure: stream 8 distinct pairs with in_valid=1 and out_ready toggling 1,0,0,1,... -> in_ready tracks adv, outputs held stable while stalled, all 8 results in order with none dropped or duplicated, mode/scale correctly attached to each.
- Reset mid-stream: assert rst with 3 samples in flight -> out_valid=0 and ovf_cnt=0 immediately (asynchronously); no stale result after release; next input emerges after 3 cycles.
